// File: rtl/snappy_pkg.sv
// snappy_pkg: shared constants, the unsolved-token record and line-address
// helpers for the Snappy result-RAM front end.
//   NUM_BLOCKS   : number of result RAM banks (address map assumes 16)
//   LINE_BYTES   : bytes per bank line
//   BLOCK_ADDR_W : line-address width inside one bank
//   BYTE_ADDR_W  : byte-address width of the whole 64 KiB space
package snappy_pkg;

    localparam int NUM_BLOCKS   = 16;
    localparam int LINE_BYTES   = 8;
    localparam int BLOCK_ADDR_W = 9;
    localparam int BYTE_ADDR_W  = 16;
    localparam int LINE_W       = BYTE_ADDR_W - 3;
    localparam int TOKEN_W      = BLOCK_ADDR_W + LINE_BYTES + BYTE_ADDR_W;

    typedef struct packed {
        logic [BLOCK_ADDR_W-1:0] addr;
        logic [LINE_BYTES-1:0]   mask;
        logic [BYTE_ADDR_W-1:0]  offset;
    } unsolved_tok_t;

    function automatic logic [3:0] line_to_bank(input logic [LINE_W-1:0] line);
        return line[3:0];
    endfunction

    function automatic logic [BLOCK_ADDR_W-1:0] line_to_addr(input logic [LINE_W-1:0] line);
        return line[LINE_W-1:4];
    endfunction

endpackage

// File: rtl/copy_dispatcher_retry_fifo.sv
// retry_fifo: per-bank queue of unsolved read tokens awaiting re-issue.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous empty (page end)
//   push/push_data : enqueue; ignored when full unless a pop happens too
//   pop        : dequeue head (ignored when empty)
//   head       : current head entry
//   empty/full : occupancy flags
//   free       : number of unused entries
module retry_fifo
    import snappy_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  unsolved_tok_t            push_data,
    input  logic                     pop,
    output unsolved_tok_t            head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int PTR_W = $clog2(DEPTH);

    unsolved_tok_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign free    = (PTR_W+1)'(DEPTH) - count;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // a pop frees the slot in the same cycle, so push-while-full is legal then
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/copy_dispatcher.sv
// copy_dispatcher: splits Snappy copy tokens into per-bank 8-byte line read
// commands for the 16 result RAM banks and re-issues unsolved tokens returned
// by the banks until every byte resolves.
//   clk, rst_n          : clock, asynchronous active-low reset
//   page_finish         : synchronous flush of all queued/in-flight state
//   tok_valid/tok_ready : copy token handshake (tok_des, tok_offset, tok_length)
//   unsolved_valid_in / unsolved_token_in : per-bank returned tokens {addr,mask,offset}
//   rd_valid_out, rd_address_out, rd_mask_out, rd_offset_out : per-bank commands
//   idle                : nothing queued, in flight or being issued
//   err_offset0         : one-cycle pulse when an offset-0 token is dropped
// Optional: define COPY_DISPATCH_STATS_EN to add saturating counters
//   stat_issued (per-bank commands issued) and stat_retries (FIFO pops).
module copy_dispatcher
    import snappy_pkg::*;
#(
    parameter int RETRY_DEPTH = 8,
    parameter int PIPE_LAT    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               page_finish,
    input  logic                               tok_valid,
    output logic                               tok_ready,
    input  logic [BYTE_ADDR_W-1:0]             tok_des,
    input  logic [BYTE_ADDR_W-1:0]             tok_offset,
    input  logic [6:0]                         tok_length,
    input  logic [NUM_BLOCKS-1:0]              unsolved_valid_in,
    input  logic [NUM_BLOCKS*TOKEN_W-1:0]      unsolved_token_in,
    output logic [NUM_BLOCKS-1:0]              rd_valid_out,
    output logic [NUM_BLOCKS*BLOCK_ADDR_W-1:0] rd_address_out,
    output logic [NUM_BLOCKS*LINE_BYTES-1:0]   rd_mask_out,
    output logic [NUM_BLOCKS*BYTE_ADDR_W-1:0]  rd_offset_out,
    output logic                               idle,
    output logic                               err_offset0
`ifdef COPY_DISPATCH_STATS_EN
    ,
    output logic [31:0]                        stat_issued,
    output logic [31:0]                        stat_retries
`endif
);

    localparam int FREE_W = $clog2(RETRY_DEPTH) + 1;

    unsolved_tok_t               fifo_head [NUM_BLOCKS];
    logic [FREE_W-1:0]           fifo_free [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]       fifo_empty;
    logic [NUM_BLOCKS-1:0]       fifo_full;
    logic [NUM_BLOCKS-1:0]       fifo_pop;
    logic                        retry_mode;
    logic                        all_free_ok;
    logic                        tok_accept;
    logic [PIPE_LAT-1:0]         inflight;

    logic [BYTE_ADDR_W-1:0]             src_addr;
    logic [NUM_BLOCKS*LINE_BYTES-1:0]   tok_mask;
    logic [NUM_BLOCKS*BLOCK_ADDR_W-1:0] tok_addr;

    logic [NUM_BLOCKS-1:0]              nxt_valid;
    logic [NUM_BLOCKS*BLOCK_ADDR_W-1:0] nxt_addr;
    logic [NUM_BLOCKS*LINE_BYTES-1:0]   nxt_mask;
    logic [NUM_BLOCKS*BYTE_ADDR_W-1:0]  nxt_offset;
    logic                               nxt_err;

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_fifo
        retry_fifo #(.DEPTH(RETRY_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (page_finish),
            .push      (unsolved_valid_in[g] & ~page_finish),
            .push_data (unsolved_tok_t'(unsolved_token_in[g*TOKEN_W +: TOKEN_W])),
            .pop       (fifo_pop[g]),
            .head      (fifo_head[g]),
            .empty     (fifo_empty[g]),
            .full      (fifo_full[g]),
            .free      (fifo_free[g])
        );
    end

    assign retry_mode = ~&fifo_empty;

    always_comb begin
        all_free_ok = 1'b1;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            if (fifo_free[i] < FREE_W'(PIPE_LAT)) all_free_ok = 1'b0;
        end
    end

    assign tok_ready  = ~page_finish & ~retry_mode & ~|fifo_full & all_free_ok;
    assign tok_accept = tok_valid & tok_ready;
    assign src_addr   = tok_des - tok_offset;

    // Bank i holds the k-th line of the span, k = i - first_line[3:0] (mod 16).
    // A byte belongs to the copy iff (byte - S) mod 2^16 < length, which covers
    // the 64 KiB wrap; lines beyond the span simply come out with an empty mask.
    always_comb begin
        logic [3:0]             k;
        logic [LINE_W-1:0]      line;
        logic [BYTE_ADDR_W-1:0] rel;
        tok_mask = '0;
        tok_addr = '0;
        k        = '0;
        line     = '0;
        rel      = '0;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            k    = 4'(i) - src_addr[6:3];
            line = src_addr[BYTE_ADDR_W-1:3] + {9'd0, k};
            tok_addr[i*BLOCK_ADDR_W +: BLOCK_ADDR_W] = line_to_addr(line);
            for (int unsigned b = 0; b < LINE_BYTES; b++) begin
                rel = {line, 3'(b)} - src_addr;
                tok_mask[i*LINE_BYTES + b] = (rel < {9'd0, tok_length});
            end
        end
    end

    always_comb begin
        nxt_valid  = '0;
        nxt_addr   = '0;
        nxt_mask   = '0;
        nxt_offset = '0;
        fifo_pop   = '0;
        nxt_err    = tok_accept & (tok_offset == '0);
        if (!page_finish) begin
            if (retry_mode) begin
                for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                    if (!fifo_empty[i]) begin
                        fifo_pop[i]  = 1'b1;
                        nxt_valid[i] = 1'b1;
                        nxt_addr[i*BLOCK_ADDR_W +: BLOCK_ADDR_W] = fifo_head[i].addr;
                        nxt_mask[i*LINE_BYTES +: LINE_BYTES]     = fifo_head[i].mask;
                        nxt_offset[i*BYTE_ADDR_W +: BYTE_ADDR_W] = fifo_head[i].offset;
                    end
                end
            end else if (tok_accept && tok_offset != '0) begin
                for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                    if (|tok_mask[i*LINE_BYTES +: LINE_BYTES]) begin
                        nxt_valid[i] = 1'b1;
                        nxt_addr[i*BLOCK_ADDR_W +: BLOCK_ADDR_W] = tok_addr[i*BLOCK_ADDR_W +: BLOCK_ADDR_W];
                        nxt_mask[i*LINE_BYTES +: LINE_BYTES]     = tok_mask[i*LINE_BYTES +: LINE_BYTES];
                        nxt_offset[i*BYTE_ADDR_W +: BYTE_ADDR_W] = tok_offset;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_out   <= '0;
            rd_address_out <= '0;
            rd_mask_out    <= '0;
            rd_offset_out  <= '0;
            err_offset0    <= 1'b0;
            inflight       <= '0;
        end else begin
            rd_valid_out   <= nxt_valid;
            rd_address_out <= nxt_addr;
            rd_mask_out    <= nxt_mask;
            rd_offset_out  <= nxt_offset;
            err_offset0    <= nxt_err;
            inflight       <= page_finish ? '0 : {inflight[PIPE_LAT-2:0], |nxt_valid};
        end
    end

    assign idle = ~retry_mode & ~|inflight & ~|rd_valid_out;

`ifdef COPY_DISPATCH_STATS_EN
    logic [31:0] issue_cnt;
    logic [31:0] pop_cnt;

    assign issue_cnt = 32'($countones(nxt_valid));
    assign pop_cnt   = 32'($countones(fifo_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_retries <= '0;
        end else if (page_finish) begin
            stat_issued  <= '0;
            stat_retries <= '0;
        end else begin
            stat_issued  <= (stat_issued > ('1 - issue_cnt)) ? '1 : stat_issued + issue_cnt;
            stat_retries <= (stat_retries > ('1 - pop_cnt)) ? '1 : stat_retries + pop_cnt;
        end
    end
`endif

endmodule

// File: doc/copy_dispatcher.md
Name: copy_dispatcher

Overview:
- Front end of the 16 result RAM banks. Accepts Snappy copy tokens (destination, offset, length) and splits each into per-bank 8-byte line read commands.
- Issues those commands to all banks in a single cycle.
- Collects the unsolved read tokens returned by the banks, queues them per bank and re-issues them until every byte is resolved.
- Byte address space is 64 KiB: 16 banks × 512 lines × 8 bytes. Line L lives in bank L[3:0] at bank address L[12:4].

Parameters:
- NUM_BLOCKS, 16, number of RAM banks; fixed at 16 because the address map depends on it.
- RETRY_DEPTH, 8, entries in each per-bank retry FIFO; must be a power of 2 and ≥ PIPE_LAT+1.
- PIPE_LAT, 4, worst-case cycles from a command issue to its unsolved token returning from a bank.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- page_finish  in  1  end of file; flush all state
- tok_valid  in  1  copy token valid
- tok_ready  out  1  copy token accepted when tok_valid & tok_ready
- tok_des  in  16  destination byte address of the first copied byte
- tok_offset  in  16  copy offset, 1..65535
- tok_length  in  7  copy length, 0..64
- unsolved_valid_in  in  16  per-bank unsolved token valid
- unsolved_token_in  in  16×33  per-bank {addr[8:0], mask[7:0], offset[15:0]}
- rd_valid_out  out  16  per-bank read command valid
- rd_address_out  out  16×9  per-bank line address
- rd_mask_out  out  16×8  per-bank byte mask; bit b = byte at line×8+b
- rd_offset_out  out  16×16  per-bank copy offset
- idle  out  1  no pending retries and nothing in flight
- err_offset0  out  1  one-cycle pulse when a token with offset 0 is dropped

Behaviour:
- Reset:
  - All rd_* outputs, err_offset0 and in-flight tracking go to 0.
  - All FIFOs go empty; idle=1.
  - tok_ready follows its combinational equation below.
- Source address: S = tok_des − tok_offset, modulo 2^16.
- Line span: lines S[15:3] through E[15:3], where E = S + tok_length − 1 (mod 2^16). This is at most 9 lines and they land in 9 distinct banks.
- Byte mask per line: bit b is set iff line×8+b falls in [S, E], computed with wrap at 2^16.
- Line addressing: line 0x1FFF is followed by line 0x0000.
- Issue timing:
  - Accepted token → outputs are registered and valid on the next cycle (latency 1).
  - Each active bank gets rd_valid=1 with rd_offset=tok_offset.
  - Inactive banks get rd_valid=0.
- Degenerate tokens:
  - tok_length=0 is accepted; nothing is issued.
  - tok_offset=0 is accepted and dropped; err_offset0 pulses 1 cycle.
- Retry FIFOs:
  - One FIFO per bank.
  - Each cycle, bank i pushes unsolved_token_in[i] when unsolved_valid_in[i] is high.
  - A push to a full FIFO is a protocol violation and must be made impossible by the tok_ready rule below.
- Arbitration:
  - Retries have strict priority over new tokens.
  - If any FIFO is non-empty, the head of every non-empty FIFO is popped and issued that cycle, and tok_ready=0.
  - A push and a pop on the same FIFO in the same cycle are both honoured.
- tok_ready = ~page_finish & all FIFOs empty & every FIFO has free entries ≥ PIPE_LAT.
- idle = all FIFOs empty & in-flight shift register (PIPE_LAT bits, 1 per issue cycle) all zero & no registered output valid.
- page_finish:
  - Synchronous flush: all FIFOs emptied, in-flight register cleared, rd_valid_out=0 next cycle.
  - Unsolved tokens arriving during the page_finish cycle are discarded.
- Reset mid-operation discards everything; there is no partial issue afterwards.

Optional Feature:
- Macro: COPY_DISPATCH_STATS_EN.
- When defined, adds outputs stat_issued[31:0] (per-bank commands issued, summed) and stat_retries[31:0] (FIFO pops).
  - Both counters saturate.
  - Both are cleared by reset and by page_finish.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package snappy_pkg holds:
  - NUM_BLOCKS, LINE_BYTES=8, BLOCK_ADDR_W=9, BYTE_ADDR_W=16
  - unsolved token typedef {addr, mask, offset}
  - helper function line_to_bank/line_to_addr
- Sub-module retry_fifo:
  - Parameterised depth; holds 33-bit entries.
  - Provides push, pop, empty, full and free-count outputs.
  - Instantiated NUM_BLOCKS times.

Test Plan:
- Aligned copy: des=0x0040, off=0x10, len=16 → next cycle rd_valid=0x00C0; banks 6 and 7 get addr 0, mask 0xFF, offset 0x10.
- Unaligned copy: des=0x0105, off=3, len=4 → bank 0 only: addr 2, mask 0x3C, offset 3.
- Maximum span: des=0x0047, off=0x40, len=64 → S=0x0007; banks 0..8 at addr 0; bank 0 mask 0x80, banks 1..7 mask 0xFF, bank 8 mask 0x7F.
- Address wrap: des=0x0002, off=0x10, len=4 → S=0xFFF2; bank 14 at addr 511, mask 0x3C.
- Retry path: inject unsolved on bank 3 {addr 5, mask 0x0F, off 0x20} while tok_valid=1 → tok_ready=0, the next cycle has rd_valid[3]=1 with those fields, then tok_ready returns to 1 and idle rises after PIPE_LAT quiet cycles.
- Flush and degenerate cases:
  - 3 unsolved tokens queued in bank 5, then page_finish → FIFOs empty, no rd_valid issued, idle=1 within PIPE_LAT+1 cycles.
  - off=0 → err_offset0 pulses and nothing is issued.
